seq_pattern_gen: RTL and testbench

//   Transmit-side companion to the serial sequence detectors. Latches a
//   PAT_W-bit pattern and a frame count, then shifts the pattern out MSB-first,
//   one bit per clock. Each frame is followed by GAP_BITS idle zeros.

---
 rtl/seq_pattern_gen_if.sv | 54 +++++
 rtl/seq_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen_if
// Brief    : Request and serial-output bundle for seq_pattern_gen. The
//            master side issues start/abort with the pattern and frame
//            count. The slave side returns the serial stream and status.
// Revision : 1.0  initial release
// ============================================================================
interface seq_pattern_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);

  // Request side
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;

  // Serial stream and status
  logic             out;
  logic             out_valid;
  logic             frame_last;
  logic             busy;
  logic             done;

  // Requester: drives start/abort/pattern/repeat_n and observes the stream
  modport master (
    output start,
    output abort,
    output pattern,
    output repeat_n,
    input  out,
    input  out_valid,
    input  frame_last,
    input  busy,
    input  done
  );

  // Generator: consumes the request and produces the stream
  modport slave (
    input  start,
    input  abort,
    input  pattern,
    input  repeat_n,
    output out,
    output out_valid,
    output frame_last,
    output busy,
    output done
  );

endinterface
`default_nettype wire

// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_pattern_gen
// Brief    : Serial pattern generator. It latches a PAT_W-bit pattern and a
//            frame count, then shifts the pattern out MSB-first, one bit per
//            clock. GAP_BITS idle zeros follow each frame. Every output is
//            registered.
// Revision : 1.0  initial release
// ============================================================================
module seq_pattern_gen #(
  parameter int PAT_W    = 4,
  parameter int CNT_W    = 4,
  parameter int GAP_BITS = 1
) (
  input  wire             clk,
  input  wire             reset,
  seq_pattern_gen_if.slave bus
);

  // Bit index within a frame; PAT_W >= 2, so this is at least one bit
  localparam int c_idx_w = $clog2(PAT_W);
  // Gap counter width; kept at one bit even when gaps are disabled
  localparam int c_gap_w = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [c_idx_w-1:0] c_idx_first = c_idx_w'(PAT_W - 1);
  localparam logic [c_gap_w-1:0] c_gap_first = c_gap_w'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);
  localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);

  // FSM encoding
  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_data = 2'd1;
  localparam logic [1:0] c_gap  = 2'd2;
  localparam logic [1:0] c_done = 2'd3;

  // State registers
  logic [1:0]         r_state;
  logic [PAT_W-1:0]   r_pat;        // pattern latched at accept
  logic [CNT_W-1:0]   r_cnt;        // frames not yet finished
  logic [c_idx_w-1:0] r_bit_idx;    // bit currently on the line
  logic [c_gap_w-1:0] r_gap_idx;    // gap bits remaining after this one

  // Registered outputs
  logic r_out;
  logic r_out_valid;
  logic r_frame_last;
  logic r_busy;
  logic r_done;

  // Next-state values
  logic [1:0]         w_state;
  logic [PAT_W-1:0]   w_pat;
  logic [CNT_W-1:0]   w_cnt;
  logic [c_idx_w-1:0] w_bit_idx;
  logic [c_gap_w-1:0] w_gap_idx;
  logic               w_accept;
  logic               w_frame_end;

  assign w_accept    = (r_state == c_idle) && bus.start && !bus.abort;
  assign w_frame_end = (r_state == c_data) && (r_bit_idx == '0);

  // Next-state logic. An abort in any active state returns to IDLE and
  // overrides the normal flow. An abort in IDLE blocks an accept.
  always_comb begin
    w_state   = r_state;
    w_pat     = r_pat;
    w_cnt     = r_cnt;
    w_bit_idx = r_bit_idx;
    w_gap_idx = r_gap_idx;

    case (r_state)
      c_idle: begin
        if (w_accept) begin
          w_pat = bus.pattern;
          w_cnt = bus.repeat_n;
          if (bus.repeat_n != '0) begin
            w_state   = c_data;
            w_bit_idx = c_idx_first;
          end else begin
            w_state = c_done;
          end
        end
      end

      c_data: begin
        if (w_frame_end) begin
          // The frame counter is only decremented. A full-scale count
          // therefore sends exactly that many frames and never wraps.
          w_cnt = r_cnt - c_cnt_one;
          if (GAP_BITS != 0) begin
            w_state   = c_gap;
            w_gap_idx = c_gap_first;
          end else if (r_cnt == c_cnt_one) begin
            w_state = c_done;
          end else begin
            w_state   = c_data;
            w_bit_idx = c_idx_first;
          end
        end else begin
          w_bit_idx = r_bit_idx - 1'b1;
        end
      end

      c_gap: begin
        if (r_gap_idx == '0) begin
          // The count was already decremented at the end of the frame
          if (r_cnt == '0) begin
            w_state = c_done;
          end else begin
            w_state   = c_data;
            w_bit_idx = c_idx_first;
          end
        end else begin
          w_gap_idx = r_gap_idx - 1'b1;
        end
      end

      default: begin
        w_state = c_idle;
      end
    endcase

    if (bus.abort && (r_state != c_idle)) begin
      w_state = c_idle;
      w_cnt   = '0;
    end
  end

  // State update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_idle;
      r_pat     <= '0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_gap_idx <= '0;
    end else begin
      r_state   <= w_state;
      r_pat     <= w_pat;
      r_cnt     <= w_cnt;
      r_bit_idx <= w_bit_idx;
      r_gap_idx <= w_gap_idx;
    end
  end

  // Outputs are registered from next-state values. The first data bit is
  // therefore on the line in the cycle right after the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_last <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_out        <= (w_state == c_data) ? w_pat[w_bit_idx] : 1'b0;
      r_out_valid  <= (w_state == c_data) || (w_state == c_gap);
      r_frame_last <= (w_state == c_data) && (w_bit_idx == '0);
      r_busy       <= (w_state != c_idle);
      r_done       <= (w_state == c_done);
    end
  end

  assign bus.out        = r_out;
  assign bus.out_valid  = r_out_valid;
  assign bus.frame_last = r_frame_last;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_pattern_gen
// Brief    : Directed self-checking bench for seq_pattern_gen. It uses one
//            instance with GAP_BITS=1 and one with GAP_BITS=0.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_pattern_gen;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  seq_pattern_gen_if #(.PAT_W(4), .CNT_W(4)) bus1 ();
  seq_pattern_gen_if #(.PAT_W(4), .CNT_W(4)) bus2 ();

  seq_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP_BITS(1)) dut_gap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  seq_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP_BITS(0)) dut_nogap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Non-overlapping 1010 detector state
  logic [3:0]  hist;
  int          hcnt;
  int          det;
  logic [14:0] stream;
  logic [7:0]  s8, l8;
  logic [4:0]  s5, v5, l5;
  logic        any_act;
  int          done_cyc;
  int          frames;
  int          nvalid;
  int          ndone;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.pattern = '0; bus1.repeat_n = '0;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.pattern = '0; bus2.repeat_n = '0;
    repeat (3) tick();

    // Reset state
    check("reset_outs", {27'd0, bus1.out, bus1.out_valid, bus1.frame_last, bus1.busy, bus1.done}, 32'd0);
    reset = 1'b0;
    tick();

    // Test 1: single 1010 frame with one gap bit; the inputs change after E0
    bus1.pattern = 4'b1010; bus1.repeat_n = 4'd1; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0; bus1.pattern = 4'b0101; bus1.repeat_n = 4'd7;
    s5 = '0; v5 = '0; l5 = '0;
    for (int c = 1; c <= 5; c++) begin
      s5 = {s5[3:0], bus1.out};
      v5 = {v5[3:0], bus1.out_valid};
      l5 = {l5[3:0], bus1.frame_last};
      tick();
    end
    check("t1_out_c1c5",   {27'd0, s5}, 32'b10100);
    check("t1_valid_c1c5", {27'd0, v5}, 32'b11111);
    check("t1_last_c1c5",  {27'd0, l5}, 32'b00010);
    check("t1_done_c6",    {31'd0, bus1.done}, 32'd1);
    tick();
    check("t1_busy_c7",    {30'd0, bus1.busy, bus1.done}, 32'd0);

    // Test 3: repeat_n=0 gives only a done pulse
    bus1.pattern = 4'b1010; bus1.repeat_n = 4'd0; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("t3_c1", {29'd0, bus1.done, bus1.out_valid, bus1.busy}, 32'b101);
    tick();
    check("t3_c2", {30'd0, bus1.busy, bus1.done}, 32'd0);

    // Test 2: three frames into a non-overlapping 1010 detector
    bus1.pattern = 4'b1010; bus1.repeat_n = 4'd3; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    hist = '0; hcnt = 0; det = 0; stream = '0; nvalid = 0; done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (bus1.out_valid) begin
        stream = {stream[13:0], bus1.out};
        nvalid++;
        hist = {hist[2:0], bus1.out};
        hcnt++;
        if (hcnt >= 4 && hist == 4'b1010) begin
          det++;
          hcnt = 0;
        end
      end
      if (bus1.done && done_cyc < 0) done_cyc = c;
      tick();
    end
    check("t2_stream",  {17'd0, stream}, 32'b101001010010100);
    check("t2_nvalid",  nvalid, 32'd15);
    check("t2_detects", det, 32'd3);
    check("t2_done_cyc", done_cyc, 32'd16);

    // Test 4: no gaps, 1100 twice; a start while busy is ignored
    bus2.pattern = 4'b1100; bus2.repeat_n = 4'd2; bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    s8 = '0; l8 = '0; done_cyc = -1;
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) begin
        s8 = {s8[6:0], bus2.out};
        l8 = {l8[6:0], bus2.frame_last};
      end
      if (bus2.done && done_cyc < 0) done_cyc = c;
      if (c == 3) begin
        bus2.start = 1'b1; bus2.pattern = 4'b1111;
      end
      if (c == 4) bus2.start = 1'b0;
      tick();
    end
    check("t4_stream",   {24'd0, s8}, 32'b11001100);
    check("t4_last",     {24'd0, l8}, 32'b00010001);
    check("t4_done_cyc", done_cyc, 32'd9);
    check("t4_idle_c10", {30'd0, bus2.busy, bus2.out_valid}, 32'd0);

    // abort wins over start in IDLE
    bus1.pattern = 4'b1010; bus1.repeat_n = 4'd1; bus1.start = 1'b1; bus1.abort = 1'b1;
    tick();
    bus1.start = 1'b0; bus1.abort = 1'b0;
    check("abort_beats_start", {30'd0, bus1.busy, bus1.out_valid}, 32'd0);

    // Test 5: abort at c2, then an immediate restart
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("t5_c1", {30'd0, bus1.out, bus1.out_valid}, 32'b11);
    tick();
    bus1.abort = 1'b1;
    tick();
    bus1.abort = 1'b0;
    check("t5_c3_after_abort", {28'd0, bus1.out_valid, bus1.busy, bus1.frame_last, bus1.done}, 32'd0);
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("t5_restart_c1", {30'd0, bus1.out, bus1.out_valid}, 32'b11);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus1.done) ndone++;
      tick();
    end
    check("t5_restart_done_count", ndone, 32'd1);

    // Test 6: reset at c3 of a five-frame transfer
    bus1.pattern = 4'b1010; bus1.repeat_n = 4'd5; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t6_reset_outs", {27'd0, bus1.out, bus1.out_valid, bus1.frame_last, bus1.busy, bus1.done}, 32'd0);
    reset = 1'b0;
    any_act = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      any_act = any_act | bus1.busy | bus1.out_valid | bus1.done;
    end
    check("t6_stays_idle", {31'd0, any_act}, 32'd0);

    // Full-scale count: exactly 15 frames, done at 15*5+1
    bus1.pattern = 4'b1010; bus1.repeat_n = 4'd15; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    frames = 0; done_cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      if (bus1.frame_last) frames++;
      if (bus1.done && done_cyc < 0) done_cyc = c;
      tick();
    end
    check("max_frames",   frames, 32'd15);
    check("max_done_cyc", done_cyc, 32'd76);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
